// File: rtl/sp_pkg.sv
//------------------------------------------------------------------------------
// sp_pkg
// Shared constants for the simple-processor instruction sequencer. It holds the
// opcode values, the T-state encoding and the bit positions of the instruction
// fields.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sp_pkg;

  // Instruction opcodes, taken from IR[7:6]
  localparam logic [1:0] IC_MV  = 2'b00;
  localparam logic [1:0] IC_MVI = 2'b01;
  localparam logic [1:0] IC_ADD = 2'b10;
  localparam logic [1:0] IC_SUB = 2'b11;

  // T-state encoding. All four codes are legal, so there is no recovery state.
  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  // Instruction field bit positions
  localparam int ICODE_MSB = 7;
  localparam int ICODE_LSB = 6;
  localparam int RX_MSB    = 5;
  localparam int RX_LSB    = 3;
  localparam int RY_MSB    = 2;
  localparam int RY_LSB    = 0;

endpackage

`default_nettype wire

// File: rtl/instr_sequencer_dec3to8.sv
//------------------------------------------------------------------------------
// dec3to8
// Converts a 3-bit register index into an 8-bit one-hot select. When the enable
// input is low, every output bit is forced to zero.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dec3to8 (
  input  logic [2:0] idx_i,
  input  logic       en_i,
  output logic [7:0] onehot_o
);

  // One output bit per register index; gated so an idle bus selects nothing
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      assign onehot_o[gi] = en_i && (idx_i == 3'(gi));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
//------------------------------------------------------------------------------
// instr_sequencer
// Instruction-fetch and T-state sequencer. It captures an instruction in T0 and
// then steps through T1..T3. Bus-select, load and ALU strobes are decoded
// combinationally from the T-state and the IR. It also keeps a wrapping count of
// retired instructions.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_sequencer
  import sp_pkg::*;
#(
  parameter int IW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [IW-1:0]    din,
  output logic [1:0]       tstate,
  output logic [1:0]       icode,
  output logic [2:0]       rin,
  output logic [7:0]       rout_sel,
  output logic             din_out,
  output logic             g_out,
  output logic             ir_load,
  output logic             a_load,
  output logic             g_load,
  output logic             addsub,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
);

  logic [1:0]       tstate_q, tstate_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] icode_w;
  logic [2:0] rx_w;
  logic [2:0] ry_w;
  logic       is_alu_w;
  logic [2:0] sel_idx_w;
  logic       sel_en_w;

  assign icode_w  = ir_q[ICODE_MSB:ICODE_LSB];
  assign rx_w     = ir_q[RX_MSB:RX_LSB];
  assign ry_w     = ir_q[RY_MSB:RY_LSB];
  // add and sub are the only opcodes with bit 1 set; they take the long path
  assign is_alu_w = icode_w[1];

  // State register: T-state, IR and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      tstate_q <= T0;
      ir_q     <= '0;
      cnt_q    <= '0;
    end else begin
      tstate_q <= tstate_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state: accept an instruction in T0; short ops return after T1, ALU ops run to T3
  always_comb begin
    tstate_d = tstate_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, done};
    case (tstate_q)
      T0: begin
        if (run) begin
          ir_d     = din;
          tstate_d = T1;
        end
      end
      T1:      tstate_d = is_alu_w ? T2 : T0;
      T2:      tstate_d = T3;
      default: tstate_d = T0;
    endcase
  end

  // Output decode: bus source, load strobes and done for the current T-state
  always_comb begin
    ir_load   = 1'b0;
    din_out   = 1'b0;
    g_out     = 1'b0;
    a_load    = 1'b0;
    g_load    = 1'b0;
    addsub    = 1'b0;
    done      = 1'b0;
    sel_idx_w = ry_w;
    sel_en_w  = 1'b0;
    case (tstate_q)
      T0: ir_load = run;
      T1: begin
        if (is_alu_w) begin
          // First ALU operand comes from the destination register
          sel_idx_w = rx_w;
          sel_en_w  = 1'b1;
          a_load    = 1'b1;
        end else if (icode_w == IC_MV) begin
          sel_en_w = 1'b1;
          done     = 1'b1;
        end else begin
          din_out = 1'b1;
          done    = 1'b1;
        end
      end
      T2: begin
        sel_en_w = 1'b1;
        g_load   = 1'b1;
        addsub   = icode_w[0];
      end
      default: begin
        g_out = 1'b1;
        done  = 1'b1;
      end
    endcase
  end

  dec3to8 u_dec3to8 (
    .idx_i    (sel_idx_w),
    .en_i     (sel_en_w),
    .onehot_o (rout_sel)
  );

  assign tstate      = tstate_q;
  assign icode       = icode_w;
  assign rin         = rx_w;
  assign instr_count = cnt_q;

endmodule

`default_nettype wire
